clock_set_ctrl: RTL and testbench

//   Time-set and alarm controller for the 12-hour BCD clock core (hh/mm/ss/pm).

---
 rtl/clock_set_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
//   Time-set and alarm controller for a 12-hour BCD clock core. Gates the
//   core's 1 Hz count enable, runs the set dialogue driven by two buttons
//   (mode/inc), issues a one-cycle load of the edited time, and holds and
//   compares a single alarm time.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   tick_1hz   in   one-cycle pulse per second
//   btn_mode   in   one-cycle pulse, advances the set state
//   btn_inc    in   one-cycle pulse, increments selected field / stops the ring
//   btn_alarm  in   one-cycle pulse, toggles alarm_on (RUN only)
//   hh,mm,ss   in   live BCD time from the clock core (hh 01..12)
//   pm         in   live AM/PM from the clock core
//   ena        out  count enable to the clock core
//   ld         out  one-cycle load strobe to the clock core
//   ld_hh      out  BCD hours to load
//   ld_mm      out  BCD minutes to load
//   ld_pm      out  AM/PM to load
//   mode       out  current state (RUN=0 SET_HH=1 SET_MM=2 AL_HH=3 AL_MM=4)
//   alarm_on   out  alarm armed
//   ring       out  alarm sounding
module clock_set_ctrl #(
    parameter int unsigned RING_SECS    = 60,
    parameter int unsigned TIMEOUT_SECS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_alarm,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       pm,
    output logic       ena,
    output logic       ld,
    output logic [7:0] ld_hh,
    output logic [7:0] ld_mm,
    output logic       ld_pm,
    output logic [2:0] mode,
    output logic       alarm_on,
    output logic       ring
);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_HH = 3'd1,
        SET_MM = 3'd2,
        AL_HH  = 3'd3,
        AL_MM  = 3'd4
    } state_t;

    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_SECS - 1);
    localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

    state_t     state_q, state_d;
    logic       ld_q, ld_d;
    logic [7:0] ed_hh_q, ed_hh_d;
    logic [7:0] ed_mm_q, ed_mm_d;
    logic       ed_pm_q, ed_pm_d;
    logic [7:0] al_hh_q, al_hh_d;
    logic [7:0] al_mm_q, al_mm_d;
    logic       al_pm_q, al_pm_d;
    logic       alarm_on_q, alarm_on_d;
    logic       ring_q, ring_d;
    logic [7:0] to_cnt_q, to_cnt_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic       match_q, match_d;

    // Returns {pm, hours}. 11->12 flips AM/PM, 12->01 keeps it.
    function automatic logic [8:0] hour_inc(input logic [7:0] h, input logic p);
        logic [8:0] r;
        if (h == 8'h11)
            r = {~p, 8'h12};
        else if (h == 8'h12)
            r = {p, 8'h01};
        else if (h[3:0] == 4'h9)
            r = {p, h[7:4] + 4'd1, 4'h0};
        else
            r = {p, h[7:4], h[3:0] + 4'd1};
        return r;
    endfunction

    // Minutes wrap 59->00 without carrying into hours.
    function automatic logic [7:0] min_inc(input logic [7:0] m);
        logic [7:0] r;
        if (m == 8'h59)
            r = 8'h00;
        else if (m[3:0] == 4'h9)
            r = {m[7:4] + 4'd1, 4'h0};
        else
            r = {m[7:4], m[3:0] + 4'd1};
        return r;
    endfunction

    logic editing;
    logic any_btn;
    logic match_now;
    logic ring_clr;

    assign editing = (state_q == SET_HH) || (state_q == SET_MM);
    assign any_btn = btn_mode | btn_inc | btn_alarm;

    // Alarm can still fire while the alarm fields are being edited, only
    // the time-edit states suppress it.
    assign match_now = alarm_on_q && (hh == al_hh_q) && (mm == al_mm_q) &&
                       (pm == al_pm_q) && (ss == 8'h00) && !editing;

    always_comb begin
        state_d    = state_q;
        ld_d       = 1'b0;
        ed_hh_d    = ed_hh_q;
        ed_mm_d    = ed_mm_q;
        ed_pm_d    = ed_pm_q;
        al_hh_d    = al_hh_q;
        al_mm_d    = al_mm_q;
        al_pm_d    = al_pm_q;
        alarm_on_d = alarm_on_q;
        ring_d     = ring_q;
        to_cnt_d   = to_cnt_q;
        ring_cnt_d = ring_cnt_q;
        match_d    = match_now;
        ring_clr   = 1'b0;

        // btn_mode takes priority over btn_inc in every state.
        unique case (state_q)
            RUN: begin
                if (btn_mode) begin
                    state_d = SET_HH;
                    ed_hh_d = hh;
                    ed_mm_d = mm;
                    ed_pm_d = pm;
                end
                if (btn_alarm)
                    alarm_on_d = ~alarm_on_q;
            end
            SET_HH: begin
                if (btn_mode)
                    state_d = SET_MM;
                else if (btn_inc)
                    {ed_pm_d, ed_hh_d} = hour_inc(ed_hh_q, ed_pm_q);
            end
            SET_MM: begin
                if (btn_mode) begin
                    state_d = AL_HH;
                    ld_d    = 1'b1;
                end else if (btn_inc) begin
                    ed_mm_d = min_inc(ed_mm_q);
                end
            end
            AL_HH: begin
                if (btn_mode)
                    state_d = AL_MM;
                else if (btn_inc)
                    {al_pm_d, al_hh_d} = hour_inc(al_hh_q, al_pm_q);
            end
            AL_MM: begin
                if (btn_mode)
                    state_d = RUN;
                else if (btn_inc)
                    al_mm_d = min_inc(al_mm_q);
            end
            default: state_d = RUN;
        endcase

        // Inactivity timeout; state changes only happen on btn_mode or on
        // the timeout itself, so both paths leave the counter at zero.
        if (any_btn) begin
            to_cnt_d = 8'd0;
        end else if (tick_1hz && (state_q != RUN)) begin
            if (to_cnt_q == TO_LAST) begin
                state_d  = RUN;
                to_cnt_d = 8'd0;
            end else begin
                to_cnt_d = to_cnt_q + 8'd1;
            end
        end

        ring_clr = (ring_q && tick_1hz && (ring_cnt_q == RING_LAST)) ||
                   (btn_inc && !btn_mode && (state_q == RUN)) ||
                   (alarm_on_q && !alarm_on_d);

        // Edge detect keeps ring from re-arming while ss stays at 00.
        if (ring_clr) begin
            ring_d     = 1'b0;
            ring_cnt_d = 8'd0;
        end else if (match_now && !match_q) begin
            ring_d     = 1'b1;
            ring_cnt_d = 8'd0;
        end else if (ring_q && tick_1hz) begin
            ring_cnt_d = ring_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            ld_q       <= 1'b0;
            ed_hh_q    <= 8'h12;
            ed_mm_q    <= 8'h00;
            ed_pm_q    <= 1'b0;
            al_hh_q    <= 8'h12;
            al_mm_q    <= 8'h00;
            al_pm_q    <= 1'b0;
            alarm_on_q <= 1'b0;
            ring_q     <= 1'b0;
            to_cnt_q   <= 8'd0;
            ring_cnt_q <= 8'd0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_q       <= ld_d;
            ed_hh_q    <= ed_hh_d;
            ed_mm_q    <= ed_mm_d;
            ed_pm_q    <= ed_pm_d;
            al_hh_q    <= al_hh_d;
            al_mm_q    <= al_mm_d;
            al_pm_q    <= al_pm_d;
            alarm_on_q <= alarm_on_d;
            ring_q     <= ring_d;
            to_cnt_q   <= to_cnt_d;
            ring_cnt_q <= ring_cnt_d;
            match_q    <= match_d;
        end
    end

    // Time is frozen while the time fields are edited and during the load.
    assign ena      = ~reset & tick_1hz & ~ld_q & ~editing;
    assign ld       = ld_q;
    assign ld_hh    = ed_hh_q;
    assign ld_mm    = ed_mm_q;
    assign ld_pm    = ed_pm_q;
    assign mode     = state_q;
    assign alarm_on = alarm_on_q;
    assign ring     = ring_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

    localparam int RING = 5;
    localparam int TOUT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic       btn_mode, btn_inc, btn_alarm;
    logic [7:0] hh, mm, ss;
    logic       pm;
    logic       ena, ld, ld_pm, alarm_on, ring;
    logic [7:0] ld_hh, ld_mm;
    logic [2:0] mode;

    int total = 0;
    int bad   = 0;

    clock_set_ctrl #(.RING_SECS(RING), .TIMEOUT_SECS(TOUT)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_alarm(btn_alarm),
        .hh(hh), .mm(mm), .ss(ss), .pm(pm),
        .ena(ena), .ld(ld), .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_pm(ld_pm),
        .mode(mode), .alarm_on(alarm_on), .ring(ring)
    );

    always #5 clk = ~clk;

    task automatic press(input logic m, input logic i, input logic a);
        @(negedge clk);
        btn_mode = m; btn_inc = i; btn_alarm = a;
        @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_alarm = 1'b0;
    endtask

    task automatic do_tick(output logic e);
        @(negedge clk);
        tick_1hz = 1'b1;
        #1 e = ena;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tick_1hz = 1'b1;
        #1;
        total++; if (ena !== 1'b0) begin bad++; $display("FAIL rst_ena got=%b want=0", ena); end
        total++; if (ld !== 1'b0) begin bad++; $display("FAIL rst_ld got=%b want=0", ld); end
        total++; if (ld_hh !== 8'h12) begin bad++; $display("FAIL rst_ld_hh got=%h want=12", ld_hh); end
        total++; if (ld_mm !== 8'h00) begin bad++; $display("FAIL rst_ld_mm got=%h want=00", ld_mm); end
        total++; if (ld_pm !== 1'b0) begin bad++; $display("FAIL rst_ld_pm got=%b want=0", ld_pm); end
        total++; if (mode !== 3'd0) begin bad++; $display("FAIL rst_mode got=%0d want=0", mode); end
        total++; if (alarm_on !== 1'b0) begin bad++; $display("FAIL rst_alarm_on got=%b want=0", alarm_on); end
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL rst_ring got=%b want=0", ring); end
        tick_1hz = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_run_ticks;
        logic e;
        for (int k = 0; k < 4; k++) begin
            repeat (9) @(negedge clk);
            #1;
            total++; if (ena !== 1'b0) begin bad++; $display("FAIL run_ena_idle k=%0d got=%b want=0", k, ena); end
            do_tick(e);
            total++; if (e !== 1'b1) begin bad++; $display("FAIL run_ena_tick k=%0d got=%b want=1", k, e); end
            total++; if (ld !== 1'b0) begin bad++; $display("FAIL run_ld k=%0d got=%b want=0", k, ld); end
            total++; if (mode !== 3'd0) begin bad++; $display("FAIL run_mode k=%0d got=%0d want=0", k, mode); end
        end
    endtask

    task automatic test_set_time;
        logic e;
        hh = 8'h11; mm = 8'h59; pm = 1'b0; ss = 8'h20;
        press(1, 0, 0);
        total++; if (mode !== 3'd1) begin bad++; $display("FAIL set_mode1 got=%0d want=1", mode); end
        total++; if ({ld_pm, ld_hh, ld_mm} !== {1'b0, 8'h11, 8'h59}) begin bad++; $display("FAIL set_copy got=%b %h %h want=0 11 59", ld_pm, ld_hh, ld_mm); end
        do_tick(e);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL set_ena_hh got=%b want=0", e); end
        press(0, 1, 0);
        total++; if ({ld_pm, ld_hh} !== {1'b1, 8'h12}) begin bad++; $display("FAIL set_inc_hh got=%b %h want=1 12", ld_pm, ld_hh); end
        press(1, 0, 0);
        total++; if (mode !== 3'd2) begin bad++; $display("FAIL set_mode2 got=%0d want=2", mode); end
        do_tick(e);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL set_ena_mm got=%b want=0", e); end
        press(0, 1, 0);
        total++; if (ld_mm !== 8'h00) begin bad++; $display("FAIL set_inc_mm got=%h want=00", ld_mm); end
        total++; if (ld !== 1'b0) begin bad++; $display("FAIL set_no_early_ld got=%b want=0", ld); end
        press(1, 0, 0);
        total++; if (ld !== 1'b1) begin bad++; $display("FAIL set_ld got=%b want=1", ld); end
        total++; if ({ld_pm, ld_hh, ld_mm} !== {1'b1, 8'h12, 8'h00}) begin bad++; $display("FAIL set_ld_val got=%b %h %h want=1 12 00", ld_pm, ld_hh, ld_mm); end
        total++; if (mode !== 3'd3) begin bad++; $display("FAIL set_mode3 got=%0d want=3", mode); end
        @(negedge clk);
        total++; if (ld !== 1'b0) begin bad++; $display("FAIL set_ld_once got=%b want=0", ld); end
        press(1, 0, 0);
        press(1, 0, 0);
        total++; if (mode !== 3'd0) begin bad++; $display("FAIL set_back_run got=%0d want=0", mode); end
    endtask

    task automatic test_hour_wrap;
        logic [7:0] exp_h [13];
        logic       exp_p [13];
        exp_h = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                  8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h01};
        exp_p = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        hh = 8'h12; mm = 8'h00; pm = 1'b0;
        press(1, 0, 0);
        for (int k = 0; k < 13; k++) begin
            press(0, 1, 0);
            total++; if ({ld_pm, ld_hh} !== {exp_p[k], exp_h[k]}) begin bad++; $display("FAIL hour_seq k=%0d got=%b %h want=%b %h", k, ld_pm, ld_hh, exp_p[k], exp_h[k]); end
        end
        press(1, 0, 0);
        press(1, 0, 0);
        total++; if ({ld, ld_pm, ld_hh, ld_mm} !== {1'b1, 1'b1, 8'h01, 8'h00}) begin bad++; $display("FAIL hour_ld got=%b %b %h %h want=1 1 01 00", ld, ld_pm, ld_hh, ld_mm); end
        press(1, 0, 0);
        press(1, 0, 0);
    endtask

    task automatic test_alarm_ring;
        logic e;
        hh = 8'h03; mm = 8'h15; pm = 1'b0; ss = 8'h10;
        press(1, 0, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        for (int k = 0; k < 19; k++) press(0, 1, 0);
        press(1, 0, 0);
        for (int k = 0; k < 30; k++) press(0, 1, 0);
        press(1, 0, 0);
        total++; if (mode !== 3'd0) begin bad++; $display("FAIL al_mode got=%0d want=0", mode); end
        press(0, 0, 1);
        total++; if (alarm_on !== 1'b1) begin bad++; $display("FAIL al_on got=%b want=1", alarm_on); end
        hh = 8'h07; mm = 8'h29; pm = 1'b1; ss = 8'h00;
        repeat (2) @(negedge clk);
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL al_early got=%b want=0", ring); end
        mm = 8'h30; pm = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL al_wrong_pm got=%b want=0", ring); end
        pm = 1'b1;
        @(negedge clk);
        total++; if (ring !== 1'b1) begin bad++; $display("FAIL al_ring got=%b want=1", ring); end
        for (int k = 1; k <= RING; k++) begin
            do_tick(e);
            total++; if (ring !== (k < RING)) begin bad++; $display("FAIL al_ring_len k=%0d got=%b want=%b", k, ring, (k < RING)); end
        end
        for (int k = 0; k < 3; k++) begin
            do_tick(e);
            total++; if (ring !== 1'b0) begin bad++; $display("FAIL al_retrigger k=%0d got=%b want=0", k, ring); end
        end
    endtask

    task automatic test_ring_stop;
        @(negedge clk); ss = 8'h01;
        @(negedge clk); ss = 8'h00;
        @(negedge clk);
        total++; if (ring !== 1'b1) begin bad++; $display("FAIL stop_ring_on got=%b want=1", ring); end
        press(0, 1, 0);
        total++; if (ring !== 1'b0) begin bad++; $display("FAIL stop_inc got=%b want=0", ring); end
        total++; if ({mode, ld, ld_hh} !== {3'd0, 1'b0, 8'h03}) begin bad++; $display("FAIL stop_no_effect got=%0d %b %h want=0 0 03", mode, ld, ld_hh); end
        @(negedge clk); ss = 8'h01;
        @(negedge clk); ss = 8'h00;
        @(negedge clk);
        total++; if (ring !== 1'b1) begin bad++; $display("FAIL stop_ring_on2 got=%b want=1", ring); end
        press(0, 0, 1);
        total++; if ({alarm_on, ring} !== 2'b00) begin bad++; $display("FAIL stop_alarm_off got=%b%b want=00", alarm_on, ring); end
        press(1, 1, 0);
        total++; if ({mode, ld_pm, ld_hh} !== {3'd1, 1'b1, 8'h07}) begin bad++; $display("FAIL both_run got=%0d %b %h want=1 1 07", mode, ld_pm, ld_hh); end
        press(1, 1, 0);
        total++; if ({mode, ld_hh, ld_mm} !== {3'd2, 8'h07, 8'h30}) begin bad++; $display("FAIL both_sethh got=%0d %h %h want=2 07 30", mode, ld_hh, ld_mm); end
        press(1, 0, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        total++; if (mode !== 3'd0) begin bad++; $display("FAIL both_back_run got=%0d want=0", mode); end
    endtask

    task automatic test_timeout_and_reset;
        logic e;
        ss = 8'h45;
        press(0, 0, 1);
        total++; if (alarm_on !== 1'b1) begin bad++; $display("FAIL to_alarm_on got=%b want=1", alarm_on); end
        press(1, 0, 0);
        for (int k = 0; k < TOUT - 1; k++) begin
            do_tick(e);
            total++; if (e !== 1'b0) begin bad++; $display("FAIL to_ena_frozen k=%0d got=%b want=0", k, e); end
        end
        press(0, 1, 0);
        for (int k = 0; k < TOUT - 1; k++) do_tick(e);
        total++; if (mode !== 3'd1) begin bad++; $display("FAIL to_btn_clears got=%0d want=1", mode); end
        do_tick(e);
        total++; if ({mode, ld} !== {3'd0, 1'b0}) begin bad++; $display("FAIL to_expire got=%0d %b want=0 0", mode, ld); end
        do_tick(e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL to_ena_resume got=%b want=1", e); end
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        total++; if (mode !== 3'd2) begin bad++; $display("FAIL rst_mid_pre got=%0d want=2", mode); end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if ({mode, ld, ld_hh, ld_mm, ld_pm} !== {3'd0, 1'b0, 8'h12, 8'h00, 1'b0}) begin bad++; $display("FAIL rst_mid_edit got=%0d %b %h %h %b want=0 0 12 00 0", mode, ld, ld_hh, ld_mm, ld_pm); end
        total++; if ({ena, alarm_on, ring} !== 3'b000) begin bad++; $display("FAIL rst_mid_flags got=%b%b%b want=000", ena, alarm_on, ring); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; tick_1hz = 1'b0;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_alarm = 1'b0;
        hh = 8'h12; mm = 8'h00; ss = 8'h00; pm = 1'b0;
        test_reset();
        test_run_ticks();
        test_set_time();
        test_hour_wrap();
        test_alarm_ring();
        test_ring_stop();
        test_timeout_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
